iddr_deser_align: RTL
=====================

Name: iddr_deser_align

Overview:
- Multi-lane generic DDR input capture with per-lane 1:DESER_RATIO deserialisation and automatic bit-level word alignment (bitslip) against a training pattern.
- Sits directly behind the input pins of source-synchronous receive interfaces (e.g. ADC/serdes-style links).
- Delivers aligned parallel words plus per-lane lock/fail status to downstream framing logic.

Parameters:
- WIDTH, 4, number of input lanes.
- DESER_RATIO, 8, bits per output word per lane; even, 4..16.
- TRAIN_PATTERN, 8'h5C, DESER_RATIO-bit alignment word; first-received bit is the MSB.
- LOCK_COUNT, 16, consecutive matching words required to declare lock (1..255).
- MAX_SWEEPS, 4, full offset sweeps allowed before a lane declares failure.

Ports:
- clk  input  1  capture and logic clock; data is sampled on both edges.
- rst  input  1  asynchronous, active-high reset.
- d  input  WIDTH  DDR serial data, one bit per lane.
- train_start  input  1  one-cycle pulse that (re)starts alignment on all lanes.
- data_out  output  WIDTH*DESER_RATIO  aligned words; lane n occupies [n*DESER_RATIO +: DESER_RATIO].
- data_valid  output  1  one-cycle strobe qualifying data_out.
- lane_locked  output  WIDTH  lane is in LOCKED.
- lane_fail  output  WIDTH  lane is in FAIL.
- all_locked  output  1  AND of lane_locked.
- slip_offset  output  WIDTH*OW  current bit offset per lane, where OW = clog2(DESER_RATIO).

Behaviour:
- Capture, per lane:
  - d is registered on posedge (bit A) and on negedge (bit B).
  - Both are re-registered on posedge as q1 = A (earlier bit) and q2 = B.
- History:
  - 2*DESER_RATIO-bit shift register per lane, updated every posedge as hist <= {hist[2*DESER_RATIO-3:0], q1, q2}.
- Word strobe:
  - A shared phase counter counts 0..DESER_RATIO/2-1 and wraps.
  - The strobe fires when the counter is at its last value.
- Word select:
  - word = hist[DESER_RATIO-1+off -: DESER_RATIO].
  - off=0 selects the newest DESER_RATIO bits; off=k selects the window k bits older.
- Output timing:
  - data_out and data_valid are registered one cycle after the strobe.
  - data_valid pulses every DESER_RATIO/2 cycles, regardless of lock state.
  - Pin-to-data_out latency is 3 cycles plus word accumulation.
- Per-lane FSM states:
  - IDLE: off=0. Goes to SEARCH on train_start.
  - SEARCH, on each strobe:
    - word==TRAIN_PATTERN: go to VERIFY, match_cnt=1.
    - Otherwise: off increments modulo DESER_RATIO, and the next strobe is skipped (settle).
    - When off wraps from DESER_RATIO-1 to 0, sweep_cnt increments.
    - When sweep_cnt reaches MAX_SWEEPS: go to FAIL.
  - VERIFY, on each strobe:
    - Match: match_cnt increments; when match_cnt reaches LOCK_COUNT, go to LOCKED.
    - Mismatch: go to SEARCH with off incremented; match_cnt is cleared.
  - LOCKED: off is frozen; no pattern checking. Leaves only on train_start or rst.
  - FAIL: lane_fail=1 and off is frozen. Leaves only on train_start or rst.
- train_start in any state:
  - Every lane goes to SEARCH with off=0; match_cnt and sweep_cnt are cleared.
  - train_start takes priority over a coincident strobe evaluation.
- Reset values:
  - All FSMs IDLE; data_out=0, data_valid=0, lane_locked=0, lane_fail=0, all_locked=0, slip_offset=0.
  - History, phase counter and all counters are 0.
- Reset asserted mid-training aborts immediately. After release, lanes stay IDLE until train_start.
- Lanes are fully independent apart from the shared phase counter and train_start.

Optional Feature:
- Macro: IDDR_DESER_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, width WIDTH*16.
  - Per-lane counter increments on each VERIFY-state mismatch and saturates at 16'hFFFF.
  - Cleared by rst and by train_start.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan (WIDTH=4, DESER_RATIO=8, TRAIN_PATTERN=8'h5C, LOCK_COUNT=16):
- Release reset, no train_start, random d -> all lanes IDLE; lane_locked=0; slip_offset=0; data_valid pulses every 4 cycles.
- train_start; lanes repeat 8'h5C delayed by 0,3,5,7 bits relative to the strobe -> slip_offset = 0,5,3,1; all_locked rises after 16 matching words on the slowest lane; data_out = {4{8'h5C}}.
- One lane driven constant 0 after train_start -> after 4 full sweeps (32 slips) that lane shows lane_fail=1; the other lanes still lock.
- Locked lane, inject one corrupted word during VERIFY on a re-train -> lane returns to SEARCH, offset+1, then re-locks at the correct offset. With IDDR_DESER_ERR_CNT_EN, err_cnt for that lane = 1.
- Assert rst during SEARCH -> all outputs 0 the same cycle; train_start pulsed coincident with a strobe restarts from offset 0.
- After lock, switch input to payload 8'hA3 on all lanes -> data_out = {4{8'hA3}}; offsets and lock are unchanged despite pattern mismatches.

Source files
------------

// File: rtl/iddr_deser_align_if.sv
// Bus bundle for the DDR deserialiser / word aligner.
// err_cnt is present only when IDDR_DESER_ERR_CNT_EN is defined.
interface iddr_deser_align_if #(
    parameter int WIDTH       = 4,
    parameter int DESER_RATIO = 8
);
    localparam int OW = $clog2(DESER_RATIO);

    logic [WIDTH-1:0]             d;
    logic                         train_start;
    logic [WIDTH*DESER_RATIO-1:0] data_out;
    logic                         data_valid;
    logic [WIDTH-1:0]             lane_locked;
    logic [WIDTH-1:0]             lane_fail;
    logic                         all_locked;
    logic [WIDTH*OW-1:0]          slip_offset;
`ifdef IDDR_DESER_ERR_CNT_EN
    logic [WIDTH*16-1:0]          err_cnt;

    modport master (output d, output train_start, input data_out, input data_valid,
                    input lane_locked, input lane_fail, input all_locked,
                    input slip_offset, input err_cnt);
    modport slave  (input d, input train_start, output data_out, output data_valid,
                    output lane_locked, output lane_fail, output all_locked,
                    output slip_offset, output err_cnt);
`else
    modport master (output d, output train_start, input data_out, input data_valid,
                    input lane_locked, input lane_fail, input all_locked,
                    input slip_offset);
    modport slave  (input d, input train_start, output data_out, output data_valid,
                    output lane_locked, output lane_fail, output all_locked,
                    output slip_offset);
`endif
endinterface

// File: rtl/iddr_deser_align.sv
// Multi-lane DDR capture, 1:DESER_RATIO deserialisation and bitslip alignment.
// Optional per-lane VERIFY error counter: define IDDR_DESER_ERR_CNT_EN.
//
// state    | meaning
// S_IDLE   | waiting for train_start, offset 0
// S_SEARCH | stepping the bit offset until the training word appears
// S_VERIFY | counting consecutive matches toward LOCK_COUNT
// S_LOCKED | offset frozen, no pattern checking
// S_FAIL   | MAX_SWEEPS full sweeps without lock, offset frozen
module iddr_deser_align #(
    parameter int                     WIDTH         = 4,
    parameter int                     DESER_RATIO   = 8,
    parameter logic [DESER_RATIO-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int                     LOCK_COUNT    = 16,
    parameter int                     MAX_SWEEPS    = 4
) (
    input  logic              clk,
    input  logic              rst,
    iddr_deser_align_if.slave bus
);
    localparam int OW = $clog2(DESER_RATIO);
    localparam int HW = 2 * DESER_RATIO;
    localparam int PH = DESER_RATIO / 2;
    localparam int PW = (PH > 1) ? $clog2(PH) : 1;
    localparam int SW = $clog2(MAX_SWEEPS + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_VERIFY, S_LOCKED, S_FAIL} lane_state_t;

    logic [WIDTH-1:0]       cap_a, cap_b, q1, q2;
    logic [HW-1:0]          hist     [WIDTH];
    logic [PW-1:0]          phase;
    logic                   strobe;
    logic [DESER_RATIO-1:0] word     [WIDTH];
    lane_state_t            state_q  [WIDTH];
    lane_state_t            state_d  [WIDTH];
    logic [OW-1:0]          off_q    [WIDTH];
    logic [OW-1:0]          off_d    [WIDTH];
    logic [7:0]             match_q  [WIDTH];
    logic [7:0]             match_d  [WIDTH];
    logic [SW-1:0]          sweep_q  [WIDTH];
    logic [SW-1:0]          sweep_d  [WIDTH];
    logic                   settle_q [WIDTH];
    logic                   settle_d [WIDTH];
    logic                   slip     [WIDTH];
`ifdef IDDR_DESER_ERR_CNT_EN
    logic [15:0]            err_q    [WIDTH];
    logic [15:0]            err_d    [WIDTH];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cap_a <= '0;
        else     cap_a <= bus.d;
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) cap_b <= '0;
        else     cap_b <= bus.d;
    end

    // Bit A (posedge) precedes bit B (negedge) in the serial stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            q2 <= '0;
            for (int l = 0; l < WIDTH; l++) hist[l] <= '0;
        end else begin
            q1 <= cap_a;
            q2 <= cap_b;
            for (int l = 0; l < WIDTH; l++) hist[l] <= {hist[l][HW-3:0], q1[l], q2[l]};
        end
    end

    assign strobe = (phase == PW'(PH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         phase <= '0;
        else if (strobe) phase <= '0;
        else             phase <= phase + 1'b1;
    end

    always_comb begin
        for (int l = 0; l < WIDTH; l++) word[l] = hist[l][off_q[l] +: DESER_RATIO];
    end

    always_comb begin
        for (int l = 0; l < WIDTH; l++) begin
            state_d[l]  = state_q[l];
            off_d[l]    = off_q[l];
            match_d[l]  = match_q[l];
            sweep_d[l]  = sweep_q[l];
            settle_d[l] = settle_q[l];
            slip[l]     = 1'b0;
`ifdef IDDR_DESER_ERR_CNT_EN
            err_d[l]    = err_q[l];
`endif
            if (bus.train_start) begin
                state_d[l]  = S_SEARCH;
                off_d[l]    = '0;
                match_d[l]  = '0;
                sweep_d[l]  = '0;
                settle_d[l] = 1'b0;
`ifdef IDDR_DESER_ERR_CNT_EN
                err_d[l]    = '0;
`endif
            end else if (strobe) begin
                case (state_q[l])
                    S_SEARCH: begin
                        // The strobe right after an offset change sees a mixed window.
                        if (settle_q[l]) begin
                            settle_d[l] = 1'b0;
                        end else if (word[l] == TRAIN_PATTERN) begin
                            match_d[l] = 8'd1;
                            state_d[l] = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
                        end else begin
                            slip[l] = 1'b1;
                        end
                    end
                    S_VERIFY: begin
                        if (word[l] == TRAIN_PATTERN) begin
                            match_d[l] = match_q[l] + 8'd1;
                            if (match_q[l] + 8'd1 == 8'(LOCK_COUNT)) state_d[l] = S_LOCKED;
                        end else begin
                            match_d[l] = '0;
                            state_d[l] = S_SEARCH;
                            slip[l]    = 1'b1;
`ifdef IDDR_DESER_ERR_CNT_EN
                            if (err_q[l] != 16'hFFFF) err_d[l] = err_q[l] + 16'd1;
`endif
                        end
                    end
                    default: ;
                endcase
                if (slip[l]) begin
                    settle_d[l] = 1'b1;
                    if (off_q[l] == OW'(DESER_RATIO - 1)) begin
                        off_d[l]   = '0;
                        sweep_d[l] = sweep_q[l] + 1'b1;
                        if (sweep_q[l] + 1'b1 == SW'(MAX_SWEEPS)) state_d[l] = S_FAIL;
                    end else begin
                        off_d[l] = off_q[l] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < WIDTH; l++) begin
                state_q[l]  <= S_IDLE;
                off_q[l]    <= '0;
                match_q[l]  <= '0;
                sweep_q[l]  <= '0;
                settle_q[l] <= 1'b0;
`ifdef IDDR_DESER_ERR_CNT_EN
                err_q[l]    <= '0;
`endif
            end
        end else begin
            for (int l = 0; l < WIDTH; l++) begin
                state_q[l]  <= state_d[l];
                off_q[l]    <= off_d[l];
                match_q[l]  <= match_d[l];
                sweep_q[l]  <= sweep_d[l];
                settle_q[l] <= settle_d[l];
`ifdef IDDR_DESER_ERR_CNT_EN
                err_q[l]    <= err_d[l];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= strobe;
            if (strobe) begin
                for (int l = 0; l < WIDTH; l++) bus.data_out[l*DESER_RATIO +: DESER_RATIO] <= word[l];
            end
        end
    end

    always_comb begin
        bus.lane_locked = '0;
        bus.lane_fail   = '0;
        bus.slip_offset = '0;
`ifdef IDDR_DESER_ERR_CNT_EN
        bus.err_cnt     = '0;
`endif
        for (int l = 0; l < WIDTH; l++) begin
            bus.lane_locked[l]          = (state_q[l] == S_LOCKED);
            bus.lane_fail[l]            = (state_q[l] == S_FAIL);
            bus.slip_offset[l*OW +: OW] = off_q[l];
`ifdef IDDR_DESER_ERR_CNT_EN
            bus.err_cnt[l*16 +: 16]     = err_q[l];
`endif
        end
    end

    assign bus.all_locked = &bus.lane_locked;
endmodule
